// File: rtl/softmax_div_issuer.sv
// -----------------------------------------------------------------------------
// softmax_div_issuer
//
// Purpose:
//   Sequencer for the softmax normalisation divide stage. It buffers a vector
//   of up to DEPTH single-precision exponentials and latches their float sum.
//   It then issues one exp[i] / sum request at a time to a downstream divider
//   over a dividend/divisor/output_z strobe interface. Each quotient is
//   streamed out with a strobe/ack handshake.
//
// Parameters:
//   DEPTH        maximum vector length (power of two, 2..256)
//   AW           index width, log2(DEPTH)
//   DIV_MIN_LAT  cycles after an issue before div_z_strb is trusted
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data/in_strb/in_last        element load stream
//   sum/sum_strb                   float sum of the vector
//   div_dividend(_strb)            dividend to the divider, one-cycle strobe
//   div_divisor(_strb)             divisor to the divider, same-cycle strobe
//   div_z/div_z_strb/div_z_ack     quotient from the divider, capture pulse
//   out_data/out_strb/out_last     normalised result, held until out_ack
//   out_ack                        consumer accepts out_data
//   busy                           FSM not in IDLE
//   timeout_err                    sticky divider-timeout flag (optional)
//
// Optional feature (macro SOFTMAX_DIV_TIMEOUT_EN):
//   Adds a 16-bit watchdog in WAIT. If the divider has not answered 4096
//   cycles after an issue, a quiet NaN is emitted for that element, the
//   sticky timeout_err output is set and sequencing carries on.
//
// Timing (L = DIV_MIN_LAT, all outputs registered):
//   ISSUE state  -> strobes visible in the next cycle (the issue cycle)
//   capture      -> out_data/div_z_ack visible at issue cycle + L + 1
//   out_strb     -> visible one cycle after capture
//   period with out_ack tied high: L + 4 cycles per element
// -----------------------------------------------------------------------------
`default_nettype none

module softmax_div_issuer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int DIV_MIN_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_strb,
  input  logic        in_last,
  input  logic [31:0] sum,
  input  logic        sum_strb,
  output logic [31:0] div_dividend,
  output logic        div_dividend_strb,
  output logic [31:0] div_divisor,
  output logic        div_divisor_strb,
  input  logic [31:0] div_z,
  input  logic        div_z_strb,
  output logic        div_z_ack,
  output logic [31:0] out_data,
  output logic        out_strb,
  output logic        out_last,
  input  logic        out_ack,
  output logic        busy
`ifdef SOFTMAX_DIV_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [15:0] LAT_C   = 16'(DIV_MIN_LAT);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_mem [DEPTH];
  // Counters are one bit wider than the index so a full buffer (n == DEPTH)
  // is representable.
  logic [AW:0] r_wr_cnt;
  logic [AW:0] r_rd_idx;
  logic        r_closed;
  logic        r_sum_vld;
  logic [31:0] r_sum;
  logic [15:0] r_wait_cnt;

  logic [31:0] r_div_dividend;
  logic [31:0] r_div_divisor;
  logic        r_div_strb;
  logic        r_div_z_ack;
  logic [31:0] r_out_data;
  logic        r_out_strb;
  logic        r_out_last;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        w_in_load_state;
  logic        w_wr_en;
  logic [AW:0] w_wr_cnt_inc;
  logic        w_close_evt;
  logic        w_load_done;
  logic        w_sum_en;
  logic        w_capture;
  logic        w_timeout;
  logic        w_wait_done;
  logic        w_out_fire;
  logic [AW:0] w_rd_inc;
  logic        w_more;
  logic        w_is_last;

  logic        w_div_strb_next;
  logic        w_div_z_ack_next;
  logic        w_out_strb_next;
  logic        w_out_last_next;

  assign w_in_load_state = (r_state == S_IDLE) || (r_state == S_LOAD);

  // Once loading has closed, further in_strb pulses are dropped.
  assign w_wr_en      = in_strb && !r_closed && w_in_load_state;
  assign w_wr_cnt_inc = r_wr_cnt + ONE_C;
  assign w_close_evt  = w_wr_en && (in_last || (w_wr_cnt_inc == DEPTH_C));
  // Closing this cycle counts, so LOAD can leave right after the final write.
  assign w_load_done  = r_closed || w_close_evt;

  assign w_sum_en     = sum_strb && w_in_load_state;

  // div_z_strb may be left high by the divider, so it is only believed once
  // the full minimum latency has elapsed since the issue.
  assign w_capture    = (r_state == S_WAIT) && (r_wait_cnt == LAT_C) && div_z_strb;

  assign w_out_fire   = (r_state == S_OUT) && r_out_strb && out_ack;
  assign w_rd_inc     = r_rd_idx + ONE_C;
  assign w_more       = (w_rd_inc < r_wr_cnt);
  assign w_is_last    = (w_rd_inc == r_wr_cnt);

`ifdef SOFTMAX_DIV_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT_C = 16'd4095;
  localparam logic [31:0] QNAN_C     = 32'h7FC0_0000;

  logic [15:0] r_to_cnt;
  logic        r_timeout_err;

  assign w_timeout   = (r_state == S_WAIT) && !w_capture && (r_to_cnt == TO_LIMIT_C);
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
`endif

  assign w_wait_done = w_capture || w_timeout;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        // A single-element vector can skip LOAD when the sum is already here.
        if (in_strb) begin
          w_state_next = (in_last && r_sum_vld) ? S_ISSUE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_load_done && r_sum_vld) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (w_out_fire) begin
          w_state_next = w_more ? S_ISSUE : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values for the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_div_strb_next  = (r_state == S_ISSUE);
    w_div_z_ack_next = w_capture;
    // out_strb rises one cycle into OUT and drops the cycle after the ack.
    w_out_strb_next  = (r_state == S_OUT) && !w_out_fire;
    w_out_last_next  = w_out_strb_next && w_is_last;
  end

  // ---------------------------------------------------------------------------
  // Element buffer: write port only here, read is registered in the datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_cnt[AW-1:0]] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt       <= '0;
      r_rd_idx       <= '0;
      r_closed       <= 1'b0;
      r_sum_vld      <= 1'b0;
      r_sum          <= '0;
      r_wait_cnt     <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_div_strb     <= 1'b0;
      r_div_z_ack    <= 1'b0;
      r_out_data     <= '0;
      r_out_strb     <= 1'b0;
      r_out_last     <= 1'b0;
    end else begin
      r_div_strb  <= w_div_strb_next;
      r_div_z_ack <= w_div_z_ack_next;
      r_out_strb  <= w_out_strb_next;
      r_out_last  <= w_out_last_next;

      if (w_wr_en) begin
        r_wr_cnt <= w_wr_cnt_inc;
      end
      if (w_close_evt) begin
        r_closed <= 1'b1;
      end

      // A later sum_strb before ISSUE simply overwrites the latched sum.
      if (w_sum_en) begin
        r_sum     <= sum;
        r_sum_vld <= 1'b1;
      end

      // Divider operands only change on an issue and hold otherwise.
      if (r_state == S_ISSUE) begin
        r_div_dividend <= r_mem[r_rd_idx[AW-1:0]];
        r_div_divisor  <= r_sum;
        r_wait_cnt     <= '0;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != LAT_C)) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end

      if (w_capture) begin
        r_out_data <= div_z;
      end

      if (w_out_fire) begin
        if (w_more) begin
          r_rd_idx <= w_rd_inc;
        end else begin
          // Vector finished: forget it so IDLE starts from a clean slate.
          r_wr_cnt  <= '0;
          r_rd_idx  <= '0;
          r_sum_vld <= 1'b0;
          r_closed  <= 1'b0;
        end
      end
    end
  end

`ifdef SOFTMAX_DIV_TIMEOUT_EN
  // Watchdog: counts from the ISSUE state; on expiry the element is replaced
  // by a quiet NaN and the error is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_to_cnt != TO_LIMIT_C)) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // The NaN takes the place of the quotient for this element only.
  logic [31:0] w_out_data_sel;
  assign w_out_data_sel = w_timeout ? QNAN_C : r_out_data;
  logic        r_to_pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_pending <= 1'b0;
    end else if (w_timeout) begin
      r_to_pending <= 1'b1;
    end else if (w_capture || w_out_fire) begin
      r_to_pending <= 1'b0;
    end
  end
  assign out_data = r_to_pending ? QNAN_C : r_out_data;
  logic w_unused_sel;
  assign w_unused_sel = ^w_out_data_sel;
`else
  assign out_data = r_out_data;
`endif

  assign div_dividend      = r_div_dividend;
  assign div_divisor       = r_div_divisor;
  assign div_dividend_strb = r_div_strb;
  assign div_divisor_strb  = r_div_strb;
  assign div_z_ack         = r_div_z_ack;
  assign out_strb          = r_out_strb;
  assign out_last          = r_out_last;
  assign busy              = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_softmax_div_issuer.sv
// -----------------------------------------------------------------------------
// tb_softmax_div_issuer
//
// Directed bench for softmax_div_issuer. Stimulus pushes the expected divider
// issues and normalised outputs into queues; a monitor pops and compares them
// whenever the DUT strobes. A small divider model answers from a table of
// hand-computed quotients (x / 1.0 returns x unchanged).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_softmax_div_issuer;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int LAT       = 4;
  localparam int MODEL_LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_strb;
  logic        in_last;
  logic [31:0] sum;
  logic        sum_strb;
  logic [31:0] div_dividend;
  logic        div_dividend_strb;
  logic [31:0] div_divisor;
  logic        div_divisor_strb;
  logic [31:0] div_z;
  logic        div_z_strb;
  logic        div_z_ack;
  logic [31:0] out_data;
  logic        out_strb;
  logic        out_last;
  logic        out_ack;
  logic        busy;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  softmax_div_issuer #(
    .DEPTH       (DEPTH),
    .AW          (AW),
    .DIV_MIN_LAT (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_strb           (in_strb),
    .in_last           (in_last),
    .sum               (sum),
    .sum_strb          (sum_strb),
    .div_dividend      (div_dividend),
    .div_dividend_strb (div_dividend_strb),
    .div_divisor       (div_divisor),
    .div_divisor_strb  (div_divisor_strb),
    .div_z             (div_z),
    .div_z_strb        (div_z_strb),
    .div_z_ack         (div_z_ack),
    .out_data          (out_data),
    .out_strb          (out_strb),
    .out_last          (out_last),
    .out_ack           (out_ack),
    .busy              (busy)
`ifdef SOFTMAX_DIV_TIMEOUT_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } out_t;

  iss_t iss_q[$];
  out_t out_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_iss(input logic [31:0] a, input logic [31:0] b);
    iss_t e;
    e.a = a;
    e.b = b;
    iss_q.push_back(e);
  endtask

  task automatic push_out(input logic [31:0] d, input logic l);
    out_t e;
    e.d = d;
    e.l = l;
    out_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Divider model
  // ---------------------------------------------------------------------------
  logic        stuck = 1'b0;   // strobe stays high, data valid only at LAT
  logic        dead  = 1'b0;   // never answers
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_q;

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    if (b == 32'h3F80_0000) return a;
    case (key)
      {32'h3F80_0000, 32'h4100_0000}: return 32'h3E00_0000; // 1/8
      {32'h4000_0000, 32'h4100_0000}: return 32'h3E80_0000; // 2/8
      {32'h4040_0000, 32'h4100_0000}: return 32'h3EC0_0000; // 3/8
      {32'h4000_0000, 32'h4080_0000}: return 32'h3F00_0000; // 2/4
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_pend     = 1'b0;
      m_cnt      = 0;
      div_z      = 32'h0;
      div_z_strb = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          div_z      = m_q;
          div_z_strb = 1'b1;
          m_pend     = 1'b0;
        end
      end
      if (div_z_ack && !stuck) div_z_strb = 1'b0;
      if (div_dividend_strb && !dead) begin
        m_q    = fdiv(div_dividend, div_divisor);
        m_pend = 1'b1;
        if (stuck) begin
          m_cnt      = LAT;
          div_z      = 32'hBAD0_BAD0;
          div_z_strb = 1'b1;
        end else begin
          m_cnt      = MODEL_LAT;
          div_z_strb = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int          last_issue_cyc = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'h0;
  iss_t        mi;
  out_t        mo;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (div_dividend_strb) begin
        chk1("divisor_strb_coincident", div_divisor_strb, 1'b1);
        chk1("no_issue_while_out", out_strb, 1'b0);
        if (iss_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_extra: got dividend %h want no issue", div_dividend);
        end else begin
          mi = iss_q.pop_front();
          chk32("issue_dividend", div_dividend, mi.a);
          chk32("issue_divisor", div_divisor, mi.b);
        end
        last_issue_cyc = cyc;
      end else if (div_divisor_strb) begin
        chk1("divisor_strb_alone", div_divisor_strb, 1'b0);
      end

      if (div_z_ack && stuck) begin
        chki("stuck_capture_latency", cyc - last_issue_cyc, LAT + 1);
      end

      if (prev_hold) begin
        chk1("bp_strb_held", out_strb, 1'b1);
        chk32("bp_data_stable", out_data, prev_data);
      end

      if (out_strb && out_ack) begin
        $display("out %0d: data=%h last=%b", n_out, out_data, out_last);
        n_out++;
        if (out_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %h want no output", out_data);
        end else begin
          mo = out_q.pop_front();
          chk32("out_data", out_data, mo.d);
          chk1("out_last", out_last, mo.l);
        end
      end

      prev_hold = out_strb && !out_ack;
      prev_data = out_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc_in(input logic s, input logic [31:0] d, input logic l,
                        input logic ss, input logic [31:0] sv);
    @(negedge clk);
    in_strb  = s;
    in_data  = d;
    in_last  = l;
    sum_strb = ss;
    sum      = sv;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (i < budget && !(busy == 1'b0 && out_q.size() == 0 && iss_q.size() == 0)) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (i >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got busy=%b pending_out=%0d pending_issue=%0d want idle and empty",
               name, busy, out_q.size(), iss_q.size());
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk1({name, "_busy"}, busy, 1'b0);
    chk32({name, "_dividend"}, div_dividend, 32'h0);
    chk32({name, "_divisor"}, div_divisor, 32'h0);
    chk1({name, "_div_strb"}, div_dividend_strb | div_divisor_strb, 1'b0);
    chk1({name, "_z_ack"}, div_z_ack, 1'b0);
    chk32({name, "_out_data"}, out_data, 32'h0);
    chk1({name, "_out_strb"}, out_strb, 1'b0);
    chk1({name, "_out_last"}, out_last, 1'b0);
`ifdef SOFTMAX_DIV_TIMEOUT_EN
    chk1({name, "_timeout_err"}, timeout_err, 1'b0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = 32'h0;
    in_strb  = 1'b0;
    in_last  = 1'b0;
    sum      = 32'h0;
    sum_strb = 1'b0;
    out_ack  = 1'b1;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic vector {1,2,3,2} / 8; a first sum of 2.0 is overwritten by 8.0.
    push_iss(32'h3F80_0000, 32'h4100_0000);
    push_iss(32'h4000_0000, 32'h4100_0000);
    push_iss(32'h4040_0000, 32'h4100_0000);
    push_iss(32'h4000_0000, 32'h4100_0000);
    push_out(32'h3E00_0000, 1'b0);
    push_out(32'h3E80_0000, 1'b0);
    push_out(32'h3EC0_0000, 1'b0);
    push_out(32'h3E80_0000, 1'b1);
    cyc_in(1'b1, 32'h3F80_0000, 1'b0, 1'b1, 32'h4000_0000);
    cyc_in(1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
    cyc_in(1'b1, 32'h4040_0000, 1'b0, 1'b1, 32'h4100_0000);
    cyc_in(1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    wait_done("basic", 2000);
    repeat (2) @(negedge clk);

    // Sum before data: single element 2.0 / 4.0, issued right after the load.
    push_iss(32'h4000_0000, 32'h4080_0000);
    push_out(32'h3F00_0000, 1'b1);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h4080_0000);
    cyc_in(1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk1("sum_first_immediate_issue", div_dividend_strb, 1'b1);
    wait_done("sum_first", 2000);
    repeat (2) @(negedge clk);

    // Full buffer: 17 elements, no in_last, sum 1.0 after the 17th.
    for (int i = 0; i < DEPTH; i++) begin
      push_iss(32'h3F80_0000 + (i << 19), 32'h3F80_0000);
      push_out(32'h3F80_0000 + (i << 19), (i == DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc_in(1'b1, 32'h3F80_0000 + (i << 19), 1'b0, 1'b0, 32'h0);
    end
    cyc_in(1'b1, 32'h40A0_0000, 1'b0, 1'b0, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h3F80_0000);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    wait_done("full", 4000);
    repeat (2) @(negedge clk);

    // Back-pressure plus a stuck-high divider strobe.
    stuck   = 1'b1;
    out_ack = 1'b0;
    push_iss(32'h3F80_0000, 32'h4100_0000);
    push_iss(32'h4040_0000, 32'h4100_0000);
    push_out(32'h3E00_0000, 1'b0);
    push_out(32'h3EC0_0000, 1'b1);
    cyc_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h0);
    cyc_in(1'b1, 32'h4040_0000, 1'b1, 1'b1, 32'h4100_0000);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    begin
      int i;
      i = 0;
      while (i < 200 && out_strb !== 1'b1) begin
        @(negedge clk);
        i++;
      end
      chk1("bp_out_strb_seen", out_strb, 1'b1);
    end
    repeat (10) @(negedge clk);
    out_ack = 1'b1;
    wait_done("backpressure", 2000);
    stuck = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT of the second element, then a fresh vector.
    push_iss(32'h3F80_0000, 32'h4100_0000);
    push_out(32'h3E00_0000, 1'b0);
    push_iss(32'h4000_0000, 32'h4100_0000);
    cyc_in(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h0);
    cyc_in(1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
    cyc_in(1'b1, 32'h4040_0000, 1'b1, 1'b1, 32'h4100_0000);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    begin
      int i;
      i = 0;
      while (i < 200 && iss_q.size() != 0) begin
        @(negedge clk);
        i++;
      end
      chki("midreset_second_issue_seen", iss_q.size(), 0);
      chki("midreset_first_output_seen", out_q.size(), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    iss_q.delete();
    out_q.delete();
    repeat (2) @(negedge clk);
    push_iss(32'h4000_0000, 32'h4080_0000);
    push_iss(32'h4000_0000, 32'h4080_0000);
    push_out(32'h3F00_0000, 1'b0);
    push_out(32'h3F00_0000, 1'b1);
    cyc_in(1'b1, 32'h4000_0000, 1'b0, 1'b1, 32'h4080_0000);
    cyc_in(1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    wait_done("after_reset", 2000);
    repeat (2) @(negedge clk);

`ifdef SOFTMAX_DIV_TIMEOUT_EN
    // Divider never answers: a quiet NaN comes out and the error sticks.
    dead = 1'b1;
    push_iss(32'h3F80_0000, 32'h3F80_0000);
    push_out(32'h7FC0_0000, 1'b1);
    cyc_in(1'b1, 32'h3F80_0000, 1'b1, 1'b1, 32'h3F80_0000);
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    wait_done("timeout", 6000);
    chk1("timeout_err_sticky", timeout_err, 1'b1);
    dead = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
